// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch CSR file with exception/ertn handling, stable timer and interrupt latching.
module csr_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_ex_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);
    logic [8:0]  crmd;
    logic [2:0]  prmd;
    logic [12:0] lie;
    logic [12:0] is;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] era, badv, tid, tcfg, tval;
    logic [25:0] eentry;
    logic [31:0] save [4];
    logic        timer_en;
    logic [31:0] wd;
    logic        we, tcfg_wr, ticlr, tset;
    logic        unused;

    assign unused = csr_re;

    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            14'h00: csr_rvalue = {23'h0, crmd};
            14'h01: csr_rvalue = {29'h0, prmd};
            14'h04: csr_rvalue = {19'h0, lie};
            14'h05: csr_rvalue = {1'b0, esub, ecode, 3'h0, is};
            14'h06: csr_rvalue = era;
            14'h07: csr_rvalue = badv;
            14'h0c: csr_rvalue = {eentry, 6'h0};
            14'h30, 14'h31, 14'h32, 14'h33: csr_rvalue = save[csr_num[1:0]];
            14'h40: csr_rvalue = tid;
            14'h41: csr_rvalue = tcfg;
            14'h42: csr_rvalue = tval;
            default: csr_rvalue = 32'h0;
        endcase
    end

    // merging against the read value; TICLR reads 0 so wd[0] is exactly wmask&wvalue bit 0
    assign wd      = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
    assign we      = csr_we & ~wb_ex;
    assign tcfg_wr = we && csr_num == 14'h41;
    assign ticlr   = we && csr_num == 14'h44 && wd[0];
    assign tset    = !tcfg_wr && timer_en && tval == 32'h0;

    assign ex_entry   = {eentry, 6'h0};
    assign ertn_entry = era;
    assign has_int    = crmd[2] & |(is & lie);

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd     <= 9'h008;
            prmd     <= 3'h0;
            lie      <= 13'h0;
            is       <= 13'h0;
            ecode    <= 6'h0;
            esub     <= 9'h0;
            era      <= 32'h0;
            badv     <= 32'h0;
            eentry   <= 26'h0;
            save     <= '{default: 32'h0};
            tid      <= 32'h0;
            tcfg     <= 32'h0;
            tval     <= 32'h0;
            timer_en <= 1'b0;
        end else begin
            if (wb_ex) begin
                crmd[2:0] <= 3'h0;
                prmd      <= crmd[2:0];
                ecode     <= wb_ecode;
                esub      <= wb_esubcode;
                era       <= wb_ex_pc;
                if (wb_ecode == 6'h08)
                    badv <= wb_ex_pc;
                else if (wb_ecode == 6'h09)
                    badv <= wb_vaddr;
            end else begin
                if (we) begin
                    case (csr_num)
                        14'h00: crmd <= wd[8:0];
                        14'h01: prmd <= wd[2:0];
                        14'h04: lie <= wd[12:0] & 13'h1bff;
                        14'h05: is[1:0] <= wd[1:0];
                        14'h06: era <= wd;
                        14'h07: badv <= wd;
                        14'h0c: eentry <= wd[31:6];
                        14'h30, 14'h31, 14'h32, 14'h33: save[csr_num[1:0]] <= wd;
                        14'h40: tid <= wd;
                        14'h41: tcfg <= wd;
                        default: ;
                    endcase
                end
                // later assignment overrides a coincident CRMD write on PLV/IE
                if (ertn_flush)
                    crmd[2:0] <= prmd;
            end
            is[9:2] <= hw_int_in;
            is[12]  <= ipi_int_in;
            is[11]  <= tset | (is[11] & ~ticlr);
            if (tcfg_wr) begin
                timer_en <= wd[0];
                tval     <= {wd[31:2], 2'b00};
            end else if (timer_en) begin
                if (tval != 32'h0)
                    tval <= tval - 32'h1;
                else if (tcfg[1])
                    tval <= {tcfg[31:2], 2'b00};
                else
                    timer_en <= 1'b0;
            end
        end
    end
endmodule
